// File: rtl/sine_deg.sv
// sine_deg: sin(theta degrees) as signed Q2.14. Fixed 3-cycle latency, one result per clock, no backpressure.
// Optional feature macro SINE_COS_OUT_EN adds cos_value from a second read port of the same quarter-wave ROM.
module sine_deg #(
  parameter int LATENCY   = 3,
  parameter int FRAC_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] theta,
  output logic        out_valid,
  output logic [15:0] value
`ifdef SINE_COS_OUT_EN
  ,
  output logic [15:0] cos_value
`endif
);

  localparam logic [14:0] ONE = 15'(1 << FRAC_BITS);

  // Quarter-wave table: round(16384*sin(d deg)), half away from zero.
  function automatic logic [14:0] rom_f(input logic [6:0] d);
    logic [14:0] r;
    r = 15'd0;
    case (d)
      7'd0:  r = 15'd0;     7'd1:  r = 15'd286;   7'd2:  r = 15'd572;   7'd3:  r = 15'd857;   7'd4:  r = 15'd1143;
      7'd5:  r = 15'd1428;  7'd6:  r = 15'd1713;  7'd7:  r = 15'd1997;  7'd8:  r = 15'd2280;  7'd9:  r = 15'd2563;
      7'd10: r = 15'd2845;  7'd11: r = 15'd3126;  7'd12: r = 15'd3406;  7'd13: r = 15'd3686;  7'd14: r = 15'd3964;
      7'd15: r = 15'd4240;  7'd16: r = 15'd4516;  7'd17: r = 15'd4790;  7'd18: r = 15'd5063;  7'd19: r = 15'd5334;
      7'd20: r = 15'd5604;  7'd21: r = 15'd5872;  7'd22: r = 15'd6138;  7'd23: r = 15'd6402;  7'd24: r = 15'd6664;
      7'd25: r = 15'd6924;  7'd26: r = 15'd7182;  7'd27: r = 15'd7438;  7'd28: r = 15'd7692;  7'd29: r = 15'd7943;
      7'd30: r = 15'd8192;  7'd31: r = 15'd8438;  7'd32: r = 15'd8682;  7'd33: r = 15'd8923;  7'd34: r = 15'd9162;
      7'd35: r = 15'd9397;  7'd36: r = 15'd9630;  7'd37: r = 15'd9860;  7'd38: r = 15'd10087; 7'd39: r = 15'd10311;
      7'd40: r = 15'd10531; 7'd41: r = 15'd10749; 7'd42: r = 15'd10963; 7'd43: r = 15'd11174; 7'd44: r = 15'd11381;
      7'd45: r = 15'd11585; 7'd46: r = 15'd11786; 7'd47: r = 15'd11982; 7'd48: r = 15'd12176; 7'd49: r = 15'd12365;
      7'd50: r = 15'd12551; 7'd51: r = 15'd12733; 7'd52: r = 15'd12911; 7'd53: r = 15'd13085; 7'd54: r = 15'd13255;
      7'd55: r = 15'd13421; 7'd56: r = 15'd13583; 7'd57: r = 15'd13741; 7'd58: r = 15'd13894; 7'd59: r = 15'd14044;
      7'd60: r = 15'd14189; 7'd61: r = 15'd14330; 7'd62: r = 15'd14466; 7'd63: r = 15'd14598; 7'd64: r = 15'd14726;
      7'd65: r = 15'd14849; 7'd66: r = 15'd14968; 7'd67: r = 15'd15082; 7'd68: r = 15'd15191; 7'd69: r = 15'd15296;
      7'd70: r = 15'd15396; 7'd71: r = 15'd15491; 7'd72: r = 15'd15582; 7'd73: r = 15'd15668; 7'd74: r = 15'd15749;
      7'd75: r = 15'd15826; 7'd76: r = 15'd15897; 7'd77: r = 15'd15964; 7'd78: r = 15'd16026; 7'd79: r = 15'd16083;
      7'd80: r = 15'd16135; 7'd81: r = 15'd16182; 7'd82: r = 15'd16225; 7'd83: r = 15'd16262; 7'd84: r = 15'd16294;
      7'd85: r = 15'd16322; 7'd86: r = 15'd16344; 7'd87: r = 15'd16362; 7'd88: r = 15'd16374; 7'd89: r = 15'd16382;
      7'd90: r = ONE;
      default: r = 15'd0;
    endcase
    return r;
  endfunction

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [8:0]         a_q, a_d;
  logic [6:0]         idx_q, idx_d;
  logic               neg_q, neg_d;
  logic [15:0]        value_q, value_d;
  logic [16:0]        u;
  logic [14:0]        sin_mag;

  // The offset is 92*360 rather than 91*360 so that theta = -32768..-32761
  // still lands on a non-negative value; the subtract chain covers up to 360*256.
  always_comb begin
    u = {theta[15], theta} + 17'd33120;
    for (int k = 7; k >= 0; k--) begin
      if (u >= (17'd360 << k)) u = u - (17'd360 << k);
    end
    a_d   = u[8:0];
    vld_d = {vld_q[LATENCY-2:0], in_valid};
  end

  always_comb begin
    idx_d = 7'(a_q);
    neg_d = 1'b0;
    if (a_q < 9'd90) begin
      idx_d = 7'(a_q);
    end else if (a_q < 9'd180) begin
      idx_d = 7'(9'd180 - a_q);
    end else if (a_q < 9'd270) begin
      idx_d = 7'(a_q - 9'd180);
      neg_d = 1'b1;
    end else begin
      idx_d = 7'(9'd360 - a_q);
      neg_d = 1'b1;
    end
  end

  always_comb begin
    sin_mag = rom_f(idx_q);
    value_d = neg_q ? -{1'b0, sin_mag} : {1'b0, sin_mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      a_q     <= '0;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      value_q <= '0;
    end else begin
      vld_q   <= vld_d;
      a_q     <= a_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      value_q <= value_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign value     = value_q;

`ifdef SINE_COS_OUT_EN
  // cos(a) = sin of the complementary folded index; negative strictly inside (90, 270).
  logic        cneg_q, cneg_d;
  logic [6:0]  cidx;
  logic [14:0] cos_mag;
  logic [15:0] cos_q, cos_d;

  always_comb begin
    cneg_d  = (a_q > 9'd90) && (a_q < 9'd270);
    cidx    = 7'd90 - idx_q;
    cos_mag = rom_f(cidx);
    cos_d   = cneg_q ? -{1'b0, cos_mag} : {1'b0, cos_mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cneg_q <= 1'b0;
      cos_q  <= '0;
    end else begin
      cneg_q <= cneg_d;
      cos_q  <= cos_d;
    end
  end

  assign cos_value = cos_q;
`endif

endmodule

// File: tb/tb_sine_deg.sv
// Bench for sine_deg: directed vector table, reset/valid-gap sequences, exhaustive sweep against a $sin golden.
module tb_sine_deg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] theta;
  logic        out_valid;
  logic [15:0] value;
`ifdef SINE_COS_OUT_EN
  logic [15:0] cos_value;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int th;
    int s;
    int c;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  sine_deg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .theta     (theta),
    .out_valid (out_valid),
    .value     (value)
`ifdef SINE_COS_OUT_EN
    ,
    .cos_value (cos_value)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic int deg_mod(input int t);
    return ((t % 360) + 360) % 360;
  endfunction

  function automatic int gold_sin(input int t);
    return rnd(16384.0 * $sin(real'(deg_mod(t)) * 3.14159265358979323846 / 180.0));
  endfunction

  function automatic int gold_cos(input int t);
    return rnd(16384.0 * $cos(real'(deg_mod(t)) * 3.14159265358979323846 / 180.0));
  endfunction

  task automatic add(input int th, input int s, input int c);
    vec_t v;
    v.th = th;
    v.s  = s;
    v.c  = c;
    vq.push_back(v);
  endtask

  int sv;
  logic [3:0] pat;

  initial begin
    // theta, expected sin, expected cos (hand-computed Q2.14)
    add(0, 0, 16384);        add(30, 8192, 14189);    add(90, 16384, 0);
    add(150, 8192, -14189);  add(180, 0, -16384);     add(200, -5604, -15396);
    add(270, -16384, 0);     add(300, -14189, 8192);  add(360, 0, 16384);
    add(390, 8192, 14189);   add(-30, -8192, 14189);  add(-90, -16384, 0);
    add(720, 0, 16384);      add(32767, 1997, 16262); add(-32768, -2280, 16225);
    add(-180, 0, -16384);    add(45, 11585, 11585);   add(60, 14189, 8192);

    rst = 1'b1;
    in_valid = 1'b1;
    theta = 16'd90;
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_value", int'($signed(value)), 0);
    repeat (3) @(negedge clk);
    chk("reset_hold_out_valid", int'(out_valid), 0);
    chk("reset_hold_value", int'($signed(value)), 0);
    rst = 1'b0;
    in_valid = 1'b0;

    // Back-to-back table: result for entry i appears 3 cycles after it is issued.
    for (int i = 0; i < vq.size() + 3; i++) begin
      if (i >= 3) begin
        chk($sformatf("tbl_vld th=%0d", vq[i-3].th), int'(out_valid), 1);
        chk($sformatf("tbl_sin th=%0d", vq[i-3].th), int'($signed(value)), vq[i-3].s);
`ifdef SINE_COS_OUT_EN
        chk($sformatf("tbl_cos th=%0d", vq[i-3].th), int'($signed(cos_value)), vq[i-3].c);
`endif
      end else begin
        chk("tbl_startup_vld", int'(out_valid), 0);
      end
      if (i < vq.size()) begin
        in_valid = 1'b1;
        theta = 16'(vq[i].th);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Valid gaps: 1,0,1,1 in, same pattern out 3 cycles later.
    pat = 4'b1101;
    for (int j = 0; j < 8; j++) begin
      sv = (j >= 3 && j < 7) ? int'(pat[j-3]) : 0;
      chk($sformatf("gap_vld j=%0d", j), int'(out_valid), sv);
      if (j == 3) chk("gap_val0", int'($signed(value)), 8192);
      if (j == 5) chk("gap_val2", int'($signed(value)), 14189);
      if (j == 6) chk("gap_val3", int'($signed(value)), 16384);
      in_valid = (j < 4) ? pat[j] : 1'b0;
      theta = (j == 0) ? 16'd30 : (j == 1) ? 16'd45 : (j == 2) ? 16'd60 : 16'd90;
      @(negedge clk);
    end

    // Reset asserted mid-cycle while the pipeline is full.
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      theta = 16'd90;
      @(negedge clk);
    end
    chk("prerst_vld", int'(out_valid), 1);
    chk("prerst_val", int'($signed(value)), 16384);
    #2 rst = 1'b1;
    #1;
    chk("midrst_vld", int'(out_valid), 0);
    chk("midrst_val", int'($signed(value)), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("postrst_idle j=%0d", j), int'(out_valid), 0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    theta = 16'd270;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("postrst_req j=%0d", j), int'(out_valid), (j == 2) ? 1 : 0);
      if (j == 2) chk("postrst_val", int'($signed(value)), -16384);
      @(negedge clk);
    end

    // Exhaustive sweep of every 16-bit angle.
    for (int i = 0; i < 65536 + 3; i++) begin
      if (i >= 3) begin
        sv = int'($signed(16'(i - 3)));
        chk($sformatf("exh_sin th=%0d", sv), int'($signed(value)), gold_sin(sv));
`ifdef SINE_COS_OUT_EN
        chk($sformatf("exh_cos th=%0d", sv), int'($signed(cos_value)), gold_cos(sv));
`endif
      end
      in_valid = (i < 65536);
      theta = 16'(i);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
